// File: rtl/mul_seq_ctrl.sv
// Sequencer for a multi-cycle shift-add multiplier (mul/mulh/mulhu) that stalls the pipeline until the product is ready.
// Optional feature: define MUL_ZERO_BYPASS_EN to finish zero-operand multiplies in one cycle.
module mul_seq_ctrl #(
   parameter int XLEN = 32,
   parameter int BPC  = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [3:0]      aluop,
   input  logic [XLEN-1:0] opa,
   input  logic [XLEN-1:0] opb,
   input  logic            flush,
   output logic            stall_EX,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int N  = XLEN / BPC;
   localparam int CW = $clog2(N + 1);
   localparam int AW = 2 * XLEN + BPC;

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t            state_q;
   logic [CW-1:0]     cnt_q;
   logic [AW-1:0]     acc_q;
   logic [AW-1:0]     acc_d;
   logic [AW-1:0]     partial;
   logic [XLEN-1:0]   mcand_q;
   logic [XLEN-1:0]   result_q;
   logic [1:0]        op_q;
   logic              neg_q;
   logic              done_q;

   logic              isMulOp;
   logic              isMulh;
   logic              go;
   logic [XLEN-1:0]   absA;
   logic [XLEN-1:0]   absB;
   logic [XLEN-1:0]   mcandIn;
   logic [XLEN-1:0]   mplierIn;
   logic [2*XLEN-1:0] prodFix;
   logic [XLEN-1:0]   resultFix;
`ifdef MUL_ZERO_BYPASS_EN
   logic              zeroOp;
`endif

   // The accumulator keeps BPC spare bits above the product so the add before each shift never drops a carry.
   always_comb begin
      isMulOp   = (aluop == 4'b0101) || (aluop == 4'b0110) || (aluop == 4'b0111);
      isMulh    = (aluop == 4'b0110);
      go        = start && isMulOp && !flush;
      absA      = opa[XLEN-1] ? -opa : opa;
      absB      = opb[XLEN-1] ? -opb : opb;
      mcandIn   = isMulh ? absA : opa;
      mplierIn  = isMulh ? absB : opb;
      partial   = AW'(acc_q[BPC-1:0]) * AW'(mcand_q);
      acc_d     = (acc_q + (partial << XLEN)) >> BPC;
      prodFix   = ((op_q == 2'b10) && neg_q) ? -acc_q[2*XLEN-1:0] : acc_q[2*XLEN-1:0];
      resultFix = (op_q == 2'b01) ? prodFix[XLEN-1:0] : prodFix[2*XLEN-1:XLEN];
      stall_EX  = (state_q == RUN) || (state_q == FIX) ||
                  (((state_q == IDLE) || (state_q == DONE)) && go);
   end

`ifdef MUL_ZERO_BYPASS_EN
   assign zeroOp = (opa == '0) || (opb == '0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         result_q <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (go) begin
                  state_q <= RUN;
                  cnt_q   <= CW'(N);
                  acc_q   <= AW'(mplierIn);
                  mcand_q <= mcandIn;
                  op_q    <= aluop[1:0];
                  neg_q   <= isMulh && (opa[XLEN-1] ^ opb[XLEN-1]);
`ifdef MUL_ZERO_BYPASS_EN
                  if (zeroOp) begin
                     state_q  <= DONE;
                     result_q <= '0;
                     done_q   <= 1'b1;
                  end
`endif
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               if (flush) begin
                  state_q <= IDLE;
               end else begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q - CW'(1);
                  if (cnt_q == CW'(1)) state_q <= FIX;
               end
            end
            FIX: begin
               if (flush) begin
                  state_q <= IDLE;
               end else begin
                  result_q <= resultFix;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed latency/arithmetic cases plus randomized traffic
// compared every cycle against a cycles-until-done reference model.
module tb_mul_seq_ctrl;

   localparam int XLEN = 32;
   localparam int N    = 32;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic [3:0]      aluop;
   logic [XLEN-1:0] opa;
   logic [XLEN-1:0] opb;
   logic            flush;
   logic            stall_EX;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   int nChecks = 0;
   int nFail   = 0;
   int cyc     = 0;

   bit          mRunning = 1'b0;
   bit          mDone    = 1'b0;
   int          mLeft    = 0;
   logic [31:0] mResult  = '0;
   logic [31:0] mPending = '0;

   logic        obsStall;
   logic        obsDone;
   logic        obsBusy;

   mul_seq_ctrl #(.XLEN(XLEN), .BPC(1)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .aluop    (aluop),
      .opa      (opa),
      .opb      (opb),
      .flush    (flush),
      .stall_EX (stall_EX),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference product straight from 64-bit integer arithmetic.
   function automatic logic [31:0] modelProduct(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sp;
      longint unsigned up;
      up = {32'b0, a} * {32'b0, b};
      sp = longint'($signed(a)) * longint'($signed(b));
      case (op)
         4'b0101: return up[31:0];
         4'b0110: return sp[63:32];
         default: return up[63:32];
      endcase
   endfunction

   function automatic bit modelGo();
      return start && (aluop inside {4'b0101, 4'b0110, 4'b0111}) && !flush;
   endfunction

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic applyStimulus(input bit st, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input bit fl);
      @(negedge clk);
      start = st;
      aluop = op;
      opa   = a;
      opb   = b;
      flush = fl;
   endtask

   task automatic checkOutput();
      bit g;
      g = modelGo();
      checkValue("stall_EX", {31'b0, stall_EX}, {31'b0, mRunning || g});
      checkValue("busy",     {31'b0, busy},     {31'b0, mRunning || mDone});
      checkValue("done",     {31'b0, done},     {31'b0, mDone});
      checkValue("result",   result,            mResult);
   endtask

   // Model advances across the coming rising edge: an accepted op is done N+2 cycles after launch.
   task automatic modelAdvance();
      bit g;
      bit nd;
      g  = modelGo();
      nd = 1'b0;
      if (mRunning) begin
         if (flush) begin
            mRunning = 1'b0;
         end else begin
            mLeft--;
            if (mLeft == 0) begin
               mRunning = 1'b0;
               nd       = 1'b1;
               mResult  = mPending;
            end
         end
      end else if (g) begin
`ifdef MUL_ZERO_BYPASS_EN
         if (opa == 0 || opb == 0) begin
            nd      = 1'b1;
            mResult = '0;
         end else begin
            mRunning = 1'b1;
            mLeft    = N + 1;
            mPending = modelProduct(aluop, opa, opb);
         end
`else
         mRunning = 1'b1;
         mLeft    = N + 1;
         mPending = modelProduct(aluop, opa, opb);
`endif
      end
      mDone = nd;
   endtask

   task automatic step(input bit st, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit fl);
      applyStimulus(st, op, a, b, fl);
      #1;
      obsStall = stall_EX;
      obsDone  = done;
      obsBusy  = busy;
      checkOutput();
      modelAdvance();
      cyc++;
   endtask

   task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output int lat, output logic [31:0] res);
      stalls = 0;
      lat    = -1;
      res    = 'x;
      step(1'b1, op, a, b, 1'b0);
      stalls += int'(obsStall);
      for (int k = 1; k <= 200; k++) begin
         step(1'b0, op, a, b, 1'b0);
         stalls += int'(obsStall);
         if (obsDone) begin
            lat = k;
            res = result;
            break;
         end
      end
   endtask

   initial begin
      int          stalls;
      int          lat;
      int          dones;
      int          d1;
      int          d2;
      logic [31:0] res;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [31:0] specials [6];

      specials = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1, 32'h7FFF_FFFF, 32'h2};
      rst_n = 1'b0;
      start = 1'b0;
      aluop = 4'b0000;
      opa   = '0;
      opb   = '0;
      flush = 1'b0;
      #1;
      checkValue("resetStall",  {31'b0, stall_EX}, 32'h0);
      checkValue("resetBusy",   {31'b0, busy},     32'h0);
      checkValue("resetDone",   {31'b0, done},     32'h0);
      checkValue("resetResult", result,            32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      runOp(4'b0101, 32'd7, 32'd6, stalls, lat, res);
      checkValue("mul7x6Stalls",  stalls, 32'd34);
      checkValue("mul7x6Latency", lat,    32'd34);
      checkValue("mul7x6Result",  res,    32'h0000_002A);

      // Flush on the tenth RUN cycle: idle afterwards, no done, old result kept.
      step(1'b1, 4'b0101, 32'd9, 32'd9, 1'b0);
      for (int k = 1; k <= 9; k++) step(1'b0, 4'b0101, 32'd9, 32'd9, 1'b0);
      step(1'b0, 4'b0101, 32'd9, 32'd9, 1'b1);
      step(1'b0, 4'b0101, 32'd9, 32'd9, 1'b0);
      checkValue("flushStall", {31'b0, obsStall}, 32'h0);
      checkValue("flushBusy",  {31'b0, obsBusy},  32'h0);
      dones = 0;
      for (int k = 0; k < 40; k++) begin
         step(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
         dones += int'(obsDone);
      end
      checkValue("flushNoDone", dones,  32'd0);
      checkValue("flushResult", result, 32'h0000_002A);

      runOp(4'b0110, 32'hFFFF_FFFF, 32'h2, stalls, lat, res);
      checkValue("mulhNeg1x2",  res, 32'hFFFF_FFFF);
      runOp(4'b0111, 32'hFFFF_FFFF, 32'h2, stalls, lat, res);
      checkValue("mulhuNeg1x2", res, 32'h0000_0001);
      runOp(4'b0101, 32'hFFFF_FFFF, 32'h2, stalls, lat, res);
      checkValue("mulNeg1x2",   res, 32'hFFFF_FFFE);
      runOp(4'b0110, 32'h8000_0000, 32'h8000_0000, stalls, lat, res);
      checkValue("mulhMinxMin", res, 32'h4000_0000);
      runOp(4'b0101, 32'h8000_0000, 32'h8000_0000, stalls, lat, res);
      checkValue("mulMinxMin",  res, 32'h0000_0000);

      // Back-to-back with start held: second operands are presented in the first op's done cycle.
      d1 = -1;
      d2 = -1;
      r1 = 'x;
      r2 = 'x;
      for (int k = 0; k <= 2 * (N + 2); k++) begin
         if (k < N + 2)
            step(1'b1, 4'b0101, 32'd3, 32'd5, 1'b0);
         else
            step(k < 2 * (N + 2), 4'b0101, 32'd4, 32'd4, 1'b0);
         if (obsDone && d1 < 0) begin
            d1 = k;
            r1 = result;
         end else if (obsDone) begin
            d2 = k;
            r2 = result;
         end
      end
      checkValue("b2bFirstDone", d1,      32'd34);
      checkValue("b2bGap",       d2 - d1, 32'd34);
      checkValue("b2bResult1",   r1,      32'd15);
      checkValue("b2bResult2",   r2,      32'd16);

`ifdef MUL_ZERO_BYPASS_EN
      runOp(4'b0101, 32'h0, 32'h1234, stalls, lat, res);
      checkValue("bypassLatency", lat,    32'd1);
      checkValue("bypassStalls",  stalls, 32'd1);
      checkValue("bypassResult",  res,    32'h0);
`endif

      for (int k = 0; k < 400; k++) begin
         int          r;
         logic [3:0]  op;
         logic [31:0] a;
         logic [31:0] b;
         r  = $urandom_range(0, 7);
         op = (r < 6) ? 4'(5 + r % 3) : 4'($urandom_range(0, 15));
         a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
         b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
         step(bit'($urandom_range(0, 1)), op, a, b, ($urandom_range(0, 15) == 0));
      end

      // Asynchronous reset in the middle of a multiply clears outputs before any clock edge.
      step(1'b1, 4'b0101, 32'd11, 32'd13, 1'b0);
      for (int k = 0; k < 5; k++) step(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkValue("asyncRstStall",  {31'b0, stall_EX}, 32'h0);
      checkValue("asyncRstBusy",   {31'b0, busy},     32'h0);
      checkValue("asyncRstDone",   {31'b0, done},     32'h0);
      checkValue("asyncRstResult", result,            32'h0);
      mRunning = 1'b0;
      mDone    = 1'b0;
      mResult  = '0;
      @(negedge clk);
      rst_n = 1'b1;
      runOp(4'b0101, 32'd3, 32'd5, stalls, lat, res);
      checkValue("postRstResult", res, 32'd15);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
